// File: rtl/hc165_uart_report_pkg.sv
// Shared types for the 74HC165 read-back reporter.
package hc165_uart_report_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DECIDE,
        S_SEND
    } state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx #(
    parameter int CLK_FREQ = 18_000_000,
    parameter int BAUDRATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BIT   = CLK_FREQ / BAUDRATE;
    localparam int CNT_W = $clog2(BIT);

    logic [CNT_W-1:0] cyc;
    logic [3:0]       idx;
    logic [9:0]       frame;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            cyc   <= '0;
            idx   <= '0;
            frame <= '1;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    frame <= {1'b1, data, 1'b0};
                    tx    <= 1'b0;
                    busy  <= 1'b1;
                    cyc   <= '0;
                    idx   <= '0;
                end
            end else if (cyc == CNT_W'(BIT - 1)) begin
                cyc <= '0;
                // frame[0] is always the bit currently on the line
                if (idx == 4'd9) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    tx   <= 1'b1;
                end else begin
                    idx   <= idx + 4'd1;
                    tx    <= frame[1];
                    frame <= {1'b1, frame[9:1]};
                end
            end else begin
                cyc <= cyc + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hc165_uart_report.sv
// Polls a 74HC165 and reports the 8 inputs over UART on change, on request, or once after reset.
module hc165_uart_report
    import hc165_uart_report_pkg::*;
#(
    parameter int CLK_FREQ    = 18_000_000,
    parameter int BAUDRATE    = 115_200,
    parameter int SHIFT_DIV   = 9,
    parameter int POLL_CYCLES = 180_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       sr_pl_n,
    output logic       sr_cp,
    input  logic       sr_q7,
    input  logic       report_now,
    output logic       tx,
    output logic       busy,
    output logic [7:0] data_o
);

    localparam int POLL_W = $clog2(POLL_CYCLES);
    localparam int DIV_W  = $clog2(SHIFT_DIV);

    state_t            state;
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_req;
    logic              poll_wrap;
    logic [DIV_W-1:0]  div_cnt;
    logic              div_last;
    logic [2:0]        bit_k;
    logic [7:0]        shreg;
    logic [7:0]        last_sent;
    logic              force_pend;
    logic              first_pend;
    logic              tx_start;
    logic              tx_done;
    logic              send;

    assign poll_wrap = (poll_cnt == POLL_W'(POLL_CYCLES - 1));
    assign div_last  = (div_cnt == DIV_W'(SHIFT_DIV - 1));
    // A report_now landing in the DECIDE cycle itself still forces this report.
    assign send = (shreg != last_sent) || force_pend || first_pend || report_now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            poll_cnt <= '0;
            poll_req <= 1'b0;
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + POLL_W'(1);
            if (state == S_IDLE && poll_req)
                poll_req <= 1'b0;
            if (poll_wrap)
                poll_req <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sr_pl_n    <= 1'b1;
            sr_cp      <= 1'b0;
            div_cnt    <= '0;
            bit_k      <= '0;
            shreg      <= '0;
            last_sent  <= '0;
            data_o     <= '0;
            force_pend <= 1'b0;
            first_pend <= 1'b1;
            tx_start   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (report_now)
                force_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (poll_req) begin
                        sr_pl_n <= 1'b0;
                        div_cnt <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (div_last) begin
                        sr_pl_n <= 1'b1;
                        div_cnt <= '0;
                        bit_k   <= 3'd7;
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    // sr_cp doubles as the phase flag: low phase samples Q7, high phase advances k
                    if (div_last) begin
                        div_cnt <= '0;
                        if (sr_cp) begin
                            sr_cp <= 1'b0;
                            bit_k <= bit_k - 3'd1;
                        end else begin
                            shreg[bit_k] <= sr_q7;
                            if (bit_k == 3'd0)
                                state <= S_DECIDE;
                            else
                                sr_cp <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_DECIDE: begin
                    data_o <= shreg;
                    if (send) begin
                        last_sent  <= shreg;
                        force_pend <= 1'b0;
                        first_pend <= 1'b0;
                        tx_start   <= 1'b1;
                        state      <= S_SEND;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (tx_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUDRATE(BAUDRATE)
    ) u_uart_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(tx_start),
        .data (shreg),
        .tx   (tx),
        .busy (busy),
        .done (tx_done)
    );

endmodule

// File: tb/tb_hc165_uart_report.sv
// Bench for hc165_uart_report: 74HC165 model, frame-decoding monitor with expected-byte queue.
module tb_hc165_uart_report;

    localparam int BIT  = 156;
    localparam int SDIV = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       report_now = 1'b0;
    logic       sr_pl_n;
    logic       sr_cp;
    logic       sr_q7;
    logic       tx;
    logic       busy;
    logic [7:0] data_o;

    logic [7:0] pins = 8'h00;
    logic [7:0] sr165 = 8'h00;
    logic [7:0] exp_q[$];

    int checks = 0;
    int passed = 0;
    int frames_seen = 0;

    always #5 clk = ~clk;

    hc165_uart_report #(
        .CLK_FREQ   (18_000_000),
        .BAUDRATE   (115_200),
        .SHIFT_DIV  (SDIV),
        .POLL_CYCLES(1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sr_pl_n   (sr_pl_n),
        .sr_cp     (sr_cp),
        .sr_q7     (sr_q7),
        .report_now(report_now),
        .tx        (tx),
        .busy      (busy),
        .data_o    (data_o)
    );

    // 74HC165: PL low loads D7..D0, each CP rise shifts toward Q7
    always @(negedge sr_pl_n or posedge sr_cp) begin
        if (!sr_pl_n)
            sr165 <= pins;
        else
            sr165 <= {sr165[6:0], 1'b0};
    end
    assign sr_q7 = sr165[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_pl_fall();
        int n = 0;
        while (sr_pl_n !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        while (sr_pl_n !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        check("pl_fall_seen", sr_pl_n, 1'b0);
    endtask

    // Entered at the first cycle with sr_pl_n low; returns one cycle after DECIDE.
    task automatic poll_check(input logic [7:0] prev, input logic [7:0] nw);
        int   low = 0;
        int   rises = 0;
        logic p;
        while (sr_pl_n === 1'b0 && low < 50) begin low++; @(negedge clk); end
        check("pl_low_cycles", low, SDIV);
        p = sr_cp;
        repeat (15 * SDIV) begin
            @(negedge clk);
            if (sr_cp === 1'b1 && p === 1'b0) rises++;
            p = sr_cp;
        end
        check("cp_rising_edges", rises, 7);
        check("data_o_before_decide", data_o, prev);
        @(negedge clk);
        check("data_o_after_decide", data_o, nw);
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames_seen < n && t < 6000) begin @(negedge clk); t++; end
        check("frame_count", frames_seen, n);
    endtask

    // Monitor: decode each frame at mid-bit, measure busy width, compare against the queue
    initial begin
        logic [9:0] bits;
        logic [7:0] e;
        int         len;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && busy === 1'b1) begin
                bits = '1;
                len = 0;
                aborted = 1'b0;
                for (int t = 0; t < 10 * BIT + 8; t++) begin
                    if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
                    if (busy !== 1'b1) break;
                    len++;
                    if (t % BIT == BIT / 2) bits = {tx, bits[9:1]};
                    @(negedge clk);
                end
                if (!aborted) begin
                    frames_seen++;
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_bits", bits, {1'b1, e, 1'b0});
                        check("frame_busy_cycles", len, 10 * BIT);
                    end
                end
                while (busy === 1'b1 || rst_n !== 1'b1) @(negedge clk);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        logic [7:0] v;
        int         n;
        int         gap;

        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_data_o", data_o, 8'h00);
        check("reset_pl_n", sr_pl_n, 1'b1);
        check("reset_cp", sr_cp, 1'b0);

        // first poll after reset always reports
        pins = 8'hA5;
        exp_q.push_back(8'hA5);
        rst_n = 1'b1;
        wait_pl_fall();
        poll_check(8'h00, 8'hA5);

        // unchanged inputs: no further frames
        repeat (3) begin
            wait_pl_fall();
            poll_check(8'hA5, 8'hA5);
        end
        check("frames_after_steady_polls", frames_seen, 1);

        // change between polls
        pins = 8'h3C;
        exp_q.push_back(8'h3C);
        wait_pl_fall();
        poll_check(8'hA5, 8'h3C);
        wait_frames(2);

        // report_now during SHIFT with unchanged inputs
        wait_pl_fall();
        repeat (50) @(negedge clk);
        report_now = 1'b1;
        @(negedge clk);
        report_now = 1'b0;
        exp_q.push_back(8'h3C);
        wait_frames(3);

        // report_now exactly in the DECIDE cycle counts for that DECIDE
        wait_pl_fall();
        repeat (16 * SDIV) @(negedge clk);
        report_now = 1'b1;
        @(negedge clk);
        report_now = 1'b0;
        exp_q.push_back(8'h3C);
        repeat (2) @(negedge clk);
        check("busy_after_decide_report", busy, 1'b1);
        pins = 8'h00;
        wait_frames(4);

        // toggling inputs: polls arriving during SEND are held and every frame is intact
        prev = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                n = 0;
                while (busy !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
                while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
                gap = 0;
                while (sr_pl_n !== 1'b0 && gap < 50) begin @(negedge clk); gap++; end
                check("held_poll_gap_ok", gap <= 4, 1'b1);
            end else begin
                wait_pl_fall();
            end
            v = pins;
            poll_check(prev, v);
            exp_q.push_back(v);
            prev = v;
            if (i < 5) pins = ~v;
        end
        wait_frames(10);

        // reset after 4 data bits of a frame; the truncated frame is not expected
        pins = 8'h81;
        n = 0;
        while (busy !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        repeat (5 * BIT) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset_tx", tx, 1'b1);
        check("midframe_reset_busy", busy, 1'b0);
        check("midframe_reset_data_o", data_o, 8'h00);
        check("midframe_reset_pl_n", sr_pl_n, 1'b1);
        check("midframe_reset_cp", sr_cp, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h81);
        wait_pl_fall();
        poll_check(8'h00, 8'h81);
        wait_frames(11);

        repeat (20) @(negedge clk);
        check("expected_queue_drained", exp_q.size(), 0);
        check("total_frames", frames_seen, 11);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
